// File: rtl/ddr3_top_ex_rdata_checker.sv
// Read-data checker for the DDR3 example traffic driver: compares read words against the LFSR bank and gates its stepping.
// Optional per-lane byte-enable masking is enabled with `define DDR3_EX_CHECKER_MASK_EN.
module ddr3_top_ex_rdata_checker #(
  parameter int NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [15:0]            burst_count,
  input  logic                   rdata_valid,
  input  logic [8*NUM_BYTES-1:0] rdata,
  input  logic [8*NUM_BYTES-1:0] exp_data,
`ifdef DDR3_EX_CHECKER_MASK_EN
  input  logic [NUM_BYTES-1:0]   rdata_be,
`endif
  output logic                   lfsr_enable,
  output logic                   lfsr_pause,
  output logic                   lfsr_load,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_BYTES-1:0]   pnf_per_byte,
  output logic                   pnf,
  output logic [15:0]            err_count,
  output logic [15:0]            first_err_idx
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t               state, state_nxt;
  logic [15:0]          word_cnt, count_lat;
  logic [NUM_BYTES-1:0] lane_en, lane_mis;
  logic                 word_take, last_word, start_take, any_mis;

`ifdef DDR3_EX_CHECKER_MASK_EN
  assign lane_en = rdata_be;
`else
  assign lane_en = '1;
`endif

  always_comb begin
    lane_mis = '0;
    for (int unsigned b = 0; b < NUM_BYTES; b++)
      lane_mis[b] = lane_en[b] && (rdata[8*b +: 8] != exp_data[8*b +: 8]);
  end

  assign any_mis    = |lane_mis;
  assign word_take  = (state == CHECK) && rdata_valid;
  assign last_word  = word_take && (word_cnt == count_lat - 16'd1);
  assign start_take = start && (state != CHECK);
  assign lfsr_load  = 1'b0;
  assign pnf        = &pnf_per_byte;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    lfsr_enable = 1'b0;
    lfsr_pause  = 1'b1;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nxt = (burst_count == 16'd0) ? DONE : CHECK;
      end
      CHECK: begin
        busy        = 1'b1;
        lfsr_enable = 1'b1;
        // Generators step only on the edge that consumes a word.
        lfsr_pause  = ~rdata_valid;
        if (last_word) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pnf_per_byte  <= '1;
      err_count     <= '0;
      first_err_idx <= '0;
      word_cnt      <= '0;
      count_lat     <= '0;
    end else if (start_take) begin
      pnf_per_byte  <= '1;
      err_count     <= '0;
      first_err_idx <= '0;
      word_cnt      <= '0;
      count_lat     <= burst_count;
    end else if (word_take) begin
      word_cnt     <= word_cnt + 16'd1;
      pnf_per_byte <= pnf_per_byte & ~lane_mis;
      if (any_mis) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0)    first_err_idx <= word_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_top_ex_rdata_checker.sv
// Scoreboard bench for ddr3_top_ex_rdata_checker with a local LFSR bank model driven by the DUT's enable/pause.
module tb_ddr3_top_ex_rdata_checker;

  localparam int NB = 4;

  typedef struct packed {
    logic [3:0]  pb;
    logic        pnf;
    logic [15:0] err;
    logic [15:0] idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n, start, rdata_valid;
  logic [15:0]   burst_count;
  logic [31:0]   rdata, exp_data, corrupt;
  logic          lfsr_enable, lfsr_pause, lfsr_load, busy, done, pnf;
  logic [NB-1:0] pnf_per_byte;
  logic [15:0]   err_count, first_err_idx;
  logic [7:0]    lf [NB];
  logic [31:0]   cmask [16];
`ifdef DDR3_EX_CHECKER_MASK_EN
  logic [NB-1:0] rdata_be;
  logic [NB-1:0] bemask [16];
`endif

  int   checks = 0;
  int   errors = 0;
  int   steps  = 0;
  exp_t sb[$];
  logic done_q = 1'b0;

  always #5 clk = ~clk;

  assign rdata = exp_data ^ corrupt;

  ddr3_top_ex_rdata_checker #(.NUM_BYTES(NB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .burst_count(burst_count),
    .rdata_valid(rdata_valid), .rdata(rdata), .exp_data(exp_data),
`ifdef DDR3_EX_CHECKER_MASK_EN
    .rdata_be(rdata_be),
`endif
    .lfsr_enable(lfsr_enable), .lfsr_pause(lfsr_pause), .lfsr_load(lfsr_load),
    .busy(busy), .done(done), .pnf_per_byte(pnf_per_byte), .pnf(pnf),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  function automatic logic [7:0] seed(int b);
    return 8'hA5 + 8'(b * 37);
  endfunction

  function automatic logic [7:0] step(logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [31:0] exp_word(int n);
    logic [31:0] w;
    logic [7:0]  l;
    w = '0;
    for (int b = 0; b < NB; b++) begin
      l = seed(b);
      for (int k = 0; k < n; k++) l = step(l);
      w[8*b +: 8] = l;
    end
    return w;
  endfunction

  // LFSR bank model: held at seed while disabled, steps when not paused.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!lfsr_enable || lfsr_load) lf[b] <= seed(b);
      else if (!lfsr_pause)          lf[b] <= step(lf[b]);
    end
    if (lfsr_enable && !lfsr_pause) steps = steps + 1;
  end

  always_comb begin
    exp_data = '0;
    for (int b = 0; b < NB; b++) exp_data[8*b +: 8] = lf[b];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each rising done presents a completed pass result.
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got done with empty queue expected none");
      end else begin
        e = sb.pop_front();
        chk("pnf_per_byte",  64'(pnf_per_byte),  64'(e.pb));
        chk("pnf",           64'(pnf),           64'(e.pnf));
        chk("err_count",     64'(err_count),     64'(e.err));
        chk("first_err_idx", 64'(first_err_idx), 64'(e.idx));
      end
    end
    done_q = done;
  end

  task automatic clear_masks();
    for (int i = 0; i < 16; i++) begin
      cmask[i] = '0;
`ifdef DDR3_EX_CHECKER_MASK_EN
      bemask[i] = '1;
`endif
    end
  endtask

  task automatic start_pass(input logic [15:0] cnt, input bit push, input exp_t e);
    @(negedge clk);
    start       = 1'b1;
    burst_count = cnt;
    steps       = 0;
    if (push) sb.push_back(e);
  endtask

  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start       = 1'b0;
      rdata_valid = 1'b1;
      corrupt     = cmask[i];
`ifdef DDR3_EX_CHECKER_MASK_EN
      rdata_be    = bemask[i];
`endif
      chk($sformatf("exp_word%0d", i), 64'(exp_data), 64'(exp_word(i)));
      if (gaps) begin
        @(negedge clk);
        rdata_valid = 1'b0;
        corrupt     = '0;
        #1 chk("pause_idle", 64'(lfsr_pause), 64'd1);
      end
    end
    @(negedge clk);
    start       = 1'b0;
    rdata_valid = 1'b0;
    corrupt     = '0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 20 && !done; k++) @(negedge clk);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected done=1 within 20 cycles");
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  64'(busy),          64'd0);
    chk({tag, "_done"},  64'(done),          64'd0);
    chk({tag, "_pb"},    64'(pnf_per_byte),  64'hF);
    chk({tag, "_pnf"},   64'(pnf),           64'd1);
    chk({tag, "_err"},   64'(err_count),     64'd0);
    chk({tag, "_idx"},   64'(first_err_idx), 64'd0);
    chk({tag, "_en"},    64'(lfsr_enable),   64'd0);
    chk({tag, "_pause"}, 64'(lfsr_pause),    64'd1);
  endtask

  localparam exp_t CLEAN = '{pb: 4'hF, pnf: 1'b1, err: 16'd0, idx: 16'd0};

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    burst_count = '0;
    rdata_valid = 1'b0;
    corrupt     = '0;
    clear_masks();
`ifdef DDR3_EX_CHECKER_MASK_EN
    rdata_be = '1;
`endif
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    chk("lfsr_load", 64'(lfsr_load), 64'd0);
    reset_n = 1'b1;

    // Zero-length pass goes straight to DONE without ever being busy.
    start_pass(16'd0, 1'b1, CLEAN);
    @(negedge clk);
    start = 1'b0;
    chk("b0_done", 64'(done), 64'd1);
    chk("b0_busy", 64'(busy), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("b0_busy_hold", 64'(busy), 64'd0);
    end

    // Clean back-to-back pass.
    start_pass(16'd8, 1'b1, CLEAN);
    feed(8, 1'b0);
    wait_done();
    chk("steps_b2b", 64'(steps), 64'd8);

    // Same pass with a bubble after every word.
    start_pass(16'd8, 1'b1, CLEAN);
    feed(8, 1'b1);
    wait_done();
    chk("steps_gap", 64'(steps), 64'd8);

    // Lane 2 corrupt on word 3, lane 0 on word 5.
    clear_masks();
    cmask[3] = 32'h00FF_0000;
    cmask[5] = 32'h0000_00FF;
    start_pass(16'd8, 1'b1, '{pb: 4'b1010, pnf: 1'b0, err: 16'd2, idx: 16'd3});
    feed(8, 1'b0);
    wait_done();
    clear_masks();

    // Reset after 4 of 8 words aborts; the next pass replays from seed.
    start_pass(16'd8, 1'b0, CLEAN);
    feed(4, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk_reset_vals("abort");
    start_pass(16'd8, 1'b1, CLEAN);
    feed(8, 1'b0);
    wait_done();
    chk("steps_replay", 64'(steps), 64'd8);

`ifdef DDR3_EX_CHECKER_MASK_EN
    cmask[2]  = 32'h0000_FF00;
    bemask[2] = 4'b1101;
    start_pass(16'd8, 1'b1, CLEAN);
    feed(8, 1'b0);
    wait_done();
    bemask[2] = 4'hF;
    start_pass(16'd8, 1'b1, '{pb: 4'b1101, pnf: 1'b0, err: 16'd1, idx: 16'd2});
    feed(8, 1'b0);
    wait_done();
    clear_masks();
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ddr3_top_ex_rdata_checker.md
# ddr3_top_ex_rdata_checker

Read-data checker for the DDR3 example traffic driver. It sits directly downstream of the bank of 8-bit LFSR pattern generators, one per byte lane. It compares each returned read word against the generator's expected pattern and steps the generators only when a word is consumed. It accumulates per-byte pass/fail, an error count and the first failing word index for a burst of programmable length.

## Interface
Parameters:
- NUM_BYTES, 4, number of byte lanes; data width is 8*NUM_BYTES.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle pulse that begins a check pass; sampled only in IDLE or DONE.
- burst_count  in  16  number of words to check; sampled on start.
- rdata_valid  in  1  read word present on rdata this cycle.
- rdata  in  8*NUM_BYTES  read data from the memory controller.
- exp_data  in  8*NUM_BYTES  concatenated LFSR data outputs; lane b is bits [8b+7:8b].
- lfsr_enable  out  1  drives the enable of every LFSR; low holds them at seed.
- lfsr_pause  out  1  drives the pause of every LFSR.
- lfsr_load  out  1  tied 0; the LFSR load input is not used.
- busy  out  1  high in CHECK.
- done  out  1  high in DONE.
- pnf_per_byte  out  NUM_BYTES  sticky pass-not-fail per lane; 1 = no mismatch seen.
- pnf  out  1  AND of pnf_per_byte.
- err_count  out  16  number of failing words; saturates at 16'hFFFF.
- first_err_idx  out  16  word index (0-based) of the first failing word; valid only when err_count != 0.

## Operation
- States: IDLE, CHECK, DONE.
- Reset (reset_n low at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, pnf_per_byte all 1, pnf=1, err_count=0, first_err_idx=0.
  - Word counter goes to 0.
- IDLE:
  - Outputs: lfsr_enable=0, lfsr_pause=1.
  - start with burst_count!=0: clear status to reset values, latch burst_count, go to CHECK.
  - start with burst_count==0: clear status and go directly to DONE.
- CHECK:
  - Outputs: lfsr_enable=1, lfsr_pause = ~rdata_valid. The LFSRs therefore advance exactly on the edge that consumes a word.
  - On rdata_valid, each lane b mismatches when rdata lane b != exp_data lane b.
  - Each mismatching lane clears its pnf_per_byte bit.
  - If any lane mismatches, err_count increments (saturating at 16'hFFFF). If err_count was 0, the current word index is written to first_err_idx.
  - Word counter increments on every valid word.
  - A valid word with word counter == latched count-1 is the last word: it is checked, then the state goes to DONE.
- DONE:
  - Outputs: lfsr_enable=0 (generators return to seed), lfsr_pause=1.
  - Status holds.
  - start begins a new pass exactly as from IDLE.
- Common rules:
  - rdata_valid is ignored outside CHECK.
  - start is ignored in CHECK.
  - Status fields change only on a valid word in CHECK, or on start.
  - Reset mid-pass aborts the pass; all outputs go to reset values on that edge.

## Timing
- Comparison is combinational on rdata and exp_data in the valid cycle. Status registers update on the same rising edge, so the result is visible one cycle after the valid cycle.
- The last valid word and the DONE transition occur on the same edge. done rises together with the final status values.
- start -> busy high: 1 cycle.
- lfsr_enable rises in the first CHECK cycle. The LFSRs present their seed on exp_data throughout that cycle, so the first read may arrive in that cycle.
- Back-to-back valid words are supported with no bubbles, one word per cycle.
- The word counter and the latched count are 16 bits. Maximum burst is 65535 words; there is no wrap within a pass.

## Configuration
- DDR3_EX_CHECKER_MASK_EN:
  - Defined: adds input rdata_be [NUM_BYTES-1:0]. A lane with rdata_be=0 on a valid word is excluded from comparison and cannot clear its pnf bit or cause an error. The word still counts and still advances the LFSRs.
  - Undefined: the port is absent and all lanes are always compared.

## Test plan
- Reset, start with burst_count=8, feed 8 back-to-back words equal to exp_data -> done after the 8th word; pnf=1, pnf_per_byte=4'hF, err_count=0, LFSRs stepped exactly 8 times.
- Same pass with rdata_valid toggled every other cycle -> lfsr_pause=1 in idle cycles; exp_data sequence unchanged; pass result identical.
- burst_count=8; corrupt lane 2 on word 3 and lane 0 on word 5 -> pnf_per_byte=4'b1010, pnf=0, err_count=2, first_err_idx=3.
- start with burst_count=0 -> DONE on the next cycle; busy never high; status at reset values.
- Assert reset_n low for one cycle mid-pass after 4 of 8 words -> IDLE; all outputs at reset values; a following start replays from the LFSR seed.
- Under DDR3_EX_CHECKER_MASK_EN: corrupt lane 1 with rdata_be=4'b1101 on that word -> no error recorded; corrupt with rdata_be=4'hF -> err_count=1.
